// File: rtl/mem_pkg.sv
// Shared memory-access encodings used by the store formatter, load extender and data memory.
package mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  localparam logic [LANES-1:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // One pending memory write: aligned address, lane-replicated data, byte enables.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  be;
  } store_entry_t;

endpackage

// File: rtl/store_lane_encoder.sv
// Combinational narrowing/replication of store data into byte lanes plus alignment check.
module store_lane_encoder
  import mem_pkg::*;
#(
  parameter int unsigned NBITS = DATA_W
) (
  input  logic [1:0]       size,
  input  logic [1:0]       addr_lo,
  input  logic [NBITS-1:0] data,
  output logic [NBITS-1:0] wdata,
  output logic [3:0]       be,
  output logic             err
);

  // Select lane pattern and enables by access size; reserved size is always an error.
  always_comb begin
    wdata = '0;
    be    = '0;
    err   = 1'b0;
    case (size)
      SIZE_BYTE: begin
        wdata = NBITS'({4{data[7:0]}});
        be    = 4'b0001 << addr_lo;
      end
      SIZE_HALF: begin
        wdata = NBITS'({2{data[15:0]}});
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        err   = addr_lo[0];
      end
      SIZE_WORD: begin
        wdata = data;
        be    = BE_ALL;
        err   = |addr_lo;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_data_formatter.sv
// Store path formatter: lane encoding into a 2-entry FIFO with valid/ready on both sides.
module store_data_formatter
  import mem_pkg::*;
#(
  parameter int unsigned NBITS     = DATA_W,
  parameter int unsigned ADDR_BITS = ADDR_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [NBITS-1:0]     i_data,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [1:0]           i_size,
  output logic                 o_valid,
  input  logic                 i_mem_ready,
  output logic [NBITS-1:0]     o_wdata,
  output logic [ADDR_BITS-1:0] o_waddr,
  output logic [3:0]           o_byte_en,
  output logic                 o_misaligned,
  output logic [ADDR_BITS-1:0] o_err_addr
);

  occ_e                 state_q, state_d;
  store_entry_t         mem_q [2];
  store_entry_t         mem_d [2];
  store_entry_t         new_entry;
  store_entry_t         head_q, head_d;
  logic                 rd_q, rd_d, wr_q, wr_d;
  logic                 ready_q, valid_q, mis_q;
  logic [ADDR_BITS-1:0] err_addr_q;
  logic [NBITS-1:0]     enc_wdata;
  logic [3:0]           enc_be;
  logic                 enc_err;
  logic                 accept, good, drain;

  store_lane_encoder #(.NBITS(NBITS)) u_enc (
    .size    (i_size),
    .addr_lo (i_addr[1:0]),
    .data    (i_data),
    .wdata   (enc_wdata),
    .be      (enc_be),
    .err     (enc_err)
  );

  assign accept = i_valid & ready_q;
  assign good   = accept & ~enc_err;
  assign drain  = valid_q & i_mem_ready;

  // Assemble the buffer entry for the current request.
  always_comb begin
    new_entry      = '0;
    new_entry.addr = {i_addr[ADDR_BITS-1:2], 2'b00};
    new_entry.data = enc_wdata;
    new_entry.be   = enc_be;
  end

  // Next occupancy, pointers, buffer contents and the head entry seen after the edge.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    mem_d   = mem_q;
    head_d  = '0;
    if (good) begin
      mem_d[wr_q] = new_entry;
      wr_d        = ~wr_q;
    end
    if (drain) rd_d = ~rd_q;
    case (state_q)
      OCC_EMPTY: if (good) state_d = OCC_ONE;
      OCC_ONE: begin
        if (good && !drain)      state_d = OCC_FULL;
        else if (drain && !good) state_d = OCC_EMPTY;
      end
      OCC_FULL:  if (drain) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
    if (state_d != OCC_EMPTY) head_d = mem_d[rd_d];
  end

  // Occupancy state, pointers and storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= OCC_EMPTY;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      mem_q   <= mem_d;
    end
  end

  // Registered handshake flags and head-of-buffer write outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      ready_q <= (state_d != OCC_FULL);
      valid_q <= (state_d != OCC_EMPTY);
      head_q  <= head_d;
    end
  end

  // Error pulse for one cycle after a bad accept; offending address held until the next one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mis_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      mis_q <= accept & enc_err;
      if (accept && enc_err) err_addr_q <= i_addr;
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = valid_q;
  assign o_wdata      = head_q.data;
  assign o_waddr      = head_q.addr;
  assign o_byte_en    = head_q.be;
  assign o_misaligned = mis_q;
  assign o_err_addr   = err_addr_q;

endmodule

// File: tb/tb_store_data_formatter.sv
// Self-checking bench for store_data_formatter: directed scenarios plus a randomized queue model.
module tb_store_data_formatter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic [31:0] i_addr;
  logic [1:0]  i_size;
  logic        o_valid;
  logic        i_mem_ready;
  logic [31:0] o_wdata;
  logic [31:0] o_waddr;
  logic [3:0]  o_byte_en;
  logic        o_misaligned;
  logic [31:0] o_err_addr;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ment_t;

  store_data_formatter dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_addr       (i_addr),
    .i_size       (i_size),
    .o_valid      (o_valid),
    .i_mem_ready  (i_mem_ready),
    .o_wdata      (o_wdata),
    .o_waddr      (o_waddr),
    .o_byte_en    (o_byte_en),
    .o_misaligned (o_misaligned),
    .o_err_addr   (o_err_addr)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] a,
                       input logic [1:0] s, input logic mr);
    i_valid     = v;
    i_data      = d;
    i_addr      = a;
    i_size      = s;
    i_mem_ready = mr;
  endtask

  // Reference formatting from the access rules, using plain arithmetic.
  function automatic void fmt(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] wd, output logic [3:0] be, output logic err);
    int unsigned off;
    off = a % 4;
    wd = 32'h0; be = 4'h0; err = 1'b0;
    if (s == 2'd0) begin
      wd = (d % 256) * 32'h01010101;
      be = 4'(1 << off);
    end else if (s == 2'd1) begin
      wd = (d % 65536) * 32'h00010001;
      be = (off < 2) ? 4'b0011 : 4'b1100;
      err = (off % 2) != 0;
    end else if (s == 2'd2) begin
      wd = d;
      be = 4'b1111;
      err = off != 0;
    end else begin
      err = 1'b1;
    end
  endfunction

  task automatic do_reset();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    i_rst_n = 1'b0;
    #3;
    tests++;
    if ({o_valid, o_wdata, o_waddr, o_byte_en, o_misaligned, o_err_addr} !== 102'h0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%0b wdata=%h waddr=%h be=%b mis=%0b err_addr=%h, want all 0",
               o_valid, o_wdata, o_waddr, o_byte_en, o_misaligned, o_err_addr);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready=%0b valid=%0b, want ready=1 valid=0", o_ready, o_valid);
    end
  endtask

  task automatic test_formats();
    logic [1:0]  sz [3] = '{2'd0, 2'd1, 2'd2};
    logic [31:0] dd [3] = '{32'h12345678, 32'hAAAABEEF, 32'hDEADBEEF};
    logic [31:0] aa [3] = '{32'h103, 32'h22, 32'h40};
    logic [31:0] ew [3] = '{32'h78787878, 32'hBEEFBEEF, 32'hDEADBEEF};
    logic [31:0] ea [3] = '{32'h100, 32'h20, 32'h40};
    logic [3:0]  eb [3] = '{4'b1000, 4'b1100, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, dd[i], aa[i], sz[i], 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
      tests++;
      if (o_valid !== 1'b1 || o_misaligned !== 1'b0) begin
        fails++;
        $display("FAIL fmt%0d_valid: valid=%0b mis=%0b, want valid=1 mis=0", i, o_valid, o_misaligned);
      end
      tests++;
      if (o_wdata !== ew[i]) begin
        fails++;
        $display("FAIL fmt%0d_wdata: got %h want %h", i, o_wdata, ew[i]);
      end
      tests++;
      if (o_waddr !== ea[i]) begin
        fails++;
        $display("FAIL fmt%0d_waddr: got %h want %h", i, o_waddr, ea[i]);
      end
      tests++;
      if (o_byte_en !== eb[i]) begin
        fails++;
        $display("FAIL fmt%0d_be: got %b want %b", i, o_byte_en, eb[i]);
      end
      tick();
      tests++;
      if (o_valid !== 1'b0 || o_wdata !== 32'h0 || o_byte_en !== 4'h0) begin
        fails++;
        $display("FAIL fmt%0d_drain: valid=%0b wdata=%h be=%b, want 0", i, o_valid, o_wdata, o_byte_en);
      end
    end
  endtask

  task automatic test_errors();
    logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] aa [3] = '{32'h21, 32'h42, 32'h77};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, aa[i], sz[i], 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
      tests++;
      if (o_misaligned !== 1'b1 || o_err_addr !== aa[i] || o_valid !== 1'b0) begin
        fails++;
        $display("FAIL err%0d_pulse: mis=%0b err_addr=%h valid=%0b, want 1/%h/0",
                 i, o_misaligned, o_err_addr, o_valid, aa[i]);
      end
      tick();
      tests++;
      if (o_misaligned !== 1'b0 || o_err_addr !== aa[i] || o_valid !== 1'b0) begin
        fails++;
        $display("FAIL err%0d_after: mis=%0b err_addr=%h valid=%0b, want 0/%h/0",
                 i, o_misaligned, o_err_addr, o_valid, aa[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    drive(1'b1, d[0], 32'hA0, 2'd2, 1'b0);
    tick();
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b1 || o_waddr !== 32'hA0) begin
      fails++;
      $display("FAIL b2b_first: ready=%0b valid=%0b waddr=%h, want 1/1/a0", o_ready, o_valid, o_waddr);
    end
    drive(1'b1, d[1], 32'hA4, 2'd2, 1'b0);
    tick();
    drive(1'b1, d[2], 32'hA8, 2'd2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (o_ready !== 1'b0 || o_waddr !== 32'hA0 || o_wdata !== d[0] || o_byte_en !== 4'hF) begin
        fails++;
        $display("FAIL b2b_stall%0d: ready=%0b waddr=%h wdata=%h be=%b, want 0/a0/%h/1111",
                 c, o_ready, o_waddr, o_wdata, o_byte_en, d[0]);
      end
      tick();
    end
    i_mem_ready = 1'b1;
    tick();
    tests++;
    if (o_ready !== 1'b1 || o_waddr !== 32'hA4 || o_wdata !== d[1]) begin
      fails++;
      $display("FAIL b2b_head_a4: ready=%0b waddr=%h wdata=%h, want 1/a4/%h", o_ready, o_waddr, o_wdata, d[1]);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b1 || o_waddr !== 32'hA8 || o_wdata !== d[2]) begin
      fails++;
      $display("FAIL b2b_head_a8: ready=%0b valid=%0b waddr=%h wdata=%h, want 1/1/a8/%h",
               o_ready, o_valid, o_waddr, o_wdata, d[2]);
    end
    tick();
    tests++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_empty: valid=%0b want 0", o_valid);
    end
  endtask

  task automatic test_accept_drain();
    logic [31:0] d;
    logic [31:0] a;
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      a = 32'h200 + 32'(i * 4);
      drive(1'b1, d, a, 2'd2, 1'b1);
      tick();
      tests++;
      if (o_ready !== 1'b1 || o_valid !== 1'b1 || o_waddr !== a || o_wdata !== d) begin
        fails++;
        $display("FAIL acc_drain%0d: ready=%0b valid=%0b waddr=%h wdata=%h, want 1/1/%h/%h",
                 i, o_ready, o_valid, o_waddr, o_wdata, a, d);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h11111111, 32'h300, 2'd2, 1'b0);
    tick();
    drive(1'b1, 32'h22222222, 32'h304, 2'd2, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    tests++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
      fails++;
      $display("FAIL arst_full: ready=%0b valid=%0b, want 0/1", o_ready, o_valid);
    end
    #2 i_rst_n = 1'b0;
    #1;
    tests++;
    if (o_valid !== 1'b0 || o_byte_en !== 4'h0 || o_wdata !== 32'h0 || o_waddr !== 32'h0) begin
      fails++;
      $display("FAIL arst_immediate: valid=%0b be=%b wdata=%h waddr=%h, want 0",
               o_valid, o_byte_en, o_wdata, o_waddr);
    end
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL arst_release: ready=%0b valid=%0b, want 1/0", o_ready, o_valid);
    end
    i_mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (o_valid !== 1'b0 || o_byte_en !== 4'h0) begin
        fails++;
        $display("FAIL arst_ghost%0d: valid=%0b be=%b waddr=%h, want no write", c, o_valid, o_byte_en, o_waddr);
      end
    end
  endtask

  task automatic test_random();
    ment_t       q[$];
    ment_t       e;
    ment_t       hd;
    logic        exp_mis;
    logic [31:0] exp_err_addr;
    logic        v, mr, err, acc, drn;
    logic [1:0]  s;
    logic [31:0] a, d, wd;
    logic [3:0]  be;
    logic [102:0] got, want;
    do_reset();
    exp_mis = 1'b0;
    exp_err_addr = 32'h0;
    for (int c = 0; c < 600; c++) begin
      hd = (q.size() > 0) ? q[0] : '0;
      want = {q.size() < 2, q.size() > 0, hd.data, hd.addr, hd.be, exp_mis, exp_err_addr};
      got  = {o_ready, o_valid, o_wdata, o_waddr, o_byte_en, o_misaligned, o_err_addr};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL random_cycle%0d: got %h want %h (ready,valid,wdata,waddr,be,mis,err_addr)", c, got, want);
      end
      v  = $urandom_range(0, 9) < 6;
      mr = $urandom_range(0, 1) == 1;
      s  = 2'($urandom_range(0, 3));
      d  = $urandom;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % 4) + ((s == 2'd0) ? (a % 4) : (s == 2'd1) ? (a % 4) - (a % 2) : 0);
      fmt(s, a, d, wd, be, err);
      acc = v && (q.size() < 2);
      drn = mr && (q.size() > 0);
      drive(v, d, a, s, mr);
      tick();
      if (drn) void'(q.pop_front());
      if (acc && !err) begin
        e.addr = a - (a % 4);
        e.data = wd;
        e.be   = be;
        q.push_back(e);
      end
      exp_mis = acc && err;
      if (acc && err) exp_err_addr = a;
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    tick();
    tick();
  endtask

  initial begin
    i_rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    @(negedge i_clk);
    test_reset();
    test_formats();
    test_errors();
    test_back_to_back();
    test_accept_drain();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
